// File: rtl/tcs3200_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tcs3200_freq_meter
// Brief    : Steps a TCS3200 sensor through R/G/B/C filters and counts output
//            edges per filter over a fixed gate window.
// Revision : 1.0  initial release
// ============================================================================
module tcs3200_freq_meter #(
    parameter int SETTLE_CYCLES = 5_000,
    parameter int GATE_CYCLES   = 500_000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sensor_out,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] r_cnt,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] b_cnt,
    output logic [CNT_W-1:0] c_cnt,
    output logic [3:0]       ovf
);

    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] C_SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] C_GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_GATE   = 2'd2;
    localparam logic [1:0] S_STORE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_ch;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_work;
    logic             r_sticky;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_edge;
    logic [1:0]       w_next_ch;

    assign w_edge    = r_sync2 & ~r_sync3;
    assign w_next_ch = r_ch + 2'd1;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sensor_out;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Filter code from channel index: R=00, G=11, B=01, C=10 -> s2=ch[0], s3=ch[0]^ch[1]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ch     <= 2'd0;
            r_timer  <= '0;
            r_work   <= '0;
            r_sticky <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            done     <= 1'b0;
            r_cnt    <= '0;
            g_cnt    <= '0;
            b_cnt    <= '0;
            c_cnt    <= '0;
            ovf      <= 4'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch    <= 2'd0;
                        s2      <= 1'b0;
                        s3      <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_timer == C_SETTLE_LAST) begin
                        r_timer  <= '0;
                        r_work   <= '0;
                        r_sticky <= 1'b0;
                        r_state  <= S_GATE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_GATE: begin
                    if (w_edge) begin
                        if (r_work == C_CNT_MAX) begin
                            r_sticky <= 1'b1;
                        end else begin
                            r_work <= r_work + 1'b1;
                        end
                    end
                    if (r_timer == C_GATE_LAST) begin
                        r_timer <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STORE: begin
                    case (r_ch)
                        2'd0:    r_cnt <= r_work;
                        2'd1:    g_cnt <= r_work;
                        2'd2:    b_cnt <= r_work;
                        default: c_cnt <= r_work;
                    endcase
                    ovf[r_ch] <= r_sticky;
                    if (r_ch == 2'd3) begin
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_ch    <= w_next_ch;
                        s2      <= w_next_ch[0];
                        s3      <= w_next_ch[0] ^ w_next_ch[1];
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcs3200_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tcs3200_freq_meter
// Brief    : Directed self-checking bench with a scoreboard of expected
//            filter codes, counts and overflow flags per measurement run.
// Revision : 1.0  initial release
// ============================================================================
module tb_tcs3200_freq_meter;

    localparam int SETTLE  = 4;
    localparam int GATE    = 100;
    localparam int PER_CH  = SETTLE + GATE + 1;
    localparam int RUN_LEN = 4 * PER_CH;
    localparam int BUDGET  = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sensor_out;
    logic        gen_sensor;
    logic        man_sensor;
    logic        gen_en;
    logic        s2, s3, busy, done;
    logic [15:0] r_cnt, g_cnt, b_cnt, c_cnt;
    logic [3:0]  ovf;

    logic        sat_start;
    logic        sat_sensor;
    logic        sat_s2, sat_s3, sat_busy, sat_done;
    logic [3:0]  sat_r, sat_g, sat_b, sat_c;
    logic [3:0]  sat_ovf;

    int n_pass  = 0;
    int n_total = 0;

    int code_q[$];
    int cnt_q[$];
    int tol_q[$];
    int ovf_q[$];

    always #10 clk = ~clk;

    assign sensor_out = gen_en ? gen_sensor : man_sensor;

    tcs3200_freq_meter #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sensor_out(sensor_out),
        .s2(s2), .s3(s3), .busy(busy), .done(done),
        .r_cnt(r_cnt), .g_cnt(g_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .ovf(ovf)
    );

    tcs3200_freq_meter #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(sat_start), .sensor_out(sat_sensor),
        .s2(sat_s2), .s3(sat_s3), .busy(sat_busy), .done(sat_done),
        .r_cnt(sat_r), .g_cnt(sat_g), .b_cnt(sat_b), .c_cnt(sat_c), .ovf(sat_ovf)
    );

    // Half periods in ns: red 10 clk, green 20, blue 25, clear 5 (full periods)
    function automatic int half_ns(input logic [1:0] code);
        case (code)
            2'b00:   return 100;
            2'b11:   return 200;
            2'b01:   return 250;
            default: return 50;
        endcase
    endfunction

    // Toggles sit on a 5 ns offset grid so they never coincide with a clock edge
    initial begin
        int el;
        gen_sensor = 1'b0;
        el = 0;
        #5;
        forever begin
            #10;
            el += 10;
            if (el >= half_ns({s2, s3})) begin
                gen_sensor = ~gen_sensor;
                el = 0;
            end
        end
    end

    initial begin
        sat_sensor = 1'b0;
        forever #40 sat_sensor = ~sat_sensor;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        logic ok;
        ok = ((obs - exp) >= -tol) && ((obs - exp) <= tol);
        n_total++;
        assert (ok === 1'b1) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d+/-%0d", tag, obs, exp, tol);
    endtask

    task automatic push_run(input int r, input int g, input int b, input int c,
                            input int ov, input int tol);
        code_q.push_back(0);
        code_q.push_back(3);
        code_q.push_back(1);
        code_q.push_back(2);
        cnt_q.push_back(r);
        cnt_q.push_back(g);
        cnt_q.push_back(b);
        cnt_q.push_back(c);
        tol_q.push_back(tol);
        ovf_q.push_back(ov);
    endtask

    task automatic run(input int stop_cyc, input int inject_cyc, input int rise_cyc,
                       output int done_cyc, output int done_cnt);
        int         cyc;
        int         exp;
        int         tol;
        logic [1:0] prev;
        logic [15:0] obs_cnt [4];
        bit         fin;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 0;
        done_cyc = -1;
        done_cnt = 0;
        fin      = 1'b0;
        prev     = 2'b00;
        while (!fin) begin
            if (cyc == 0) check("busy_rise", {31'd0, busy}, 32'd1);
            if (cyc == 0 || {s2, s3} !== prev) begin
                exp = (code_q.size() > 0) ? code_q.pop_front() : -1;
                check("s2s3_seq", {30'd0, s2, s3}, exp);
                prev = {s2, s3};
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    obs_cnt[0] = r_cnt;
                    obs_cnt[1] = g_cnt;
                    obs_cnt[2] = b_cnt;
                    obs_cnt[3] = c_cnt;
                    tol = (tol_q.size() > 0) ? tol_q.pop_front() : 0;
                    for (int i = 0; i < 4; i++) begin
                        exp = (cnt_q.size() > 0) ? cnt_q.pop_front() : -100;
                        check_tol($sformatf("count_ch%0d", i), int'(obs_cnt[i]), exp, tol);
                    end
                    exp = (ovf_q.size() > 0) ? ovf_q.pop_front() : -1;
                    check("ovf", {28'd0, ovf}, exp);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) fin = 1'b1;
            if (cyc == stop_cyc || cyc >= BUDGET) fin = 1'b1;
            if (!fin) begin
                start = (cyc == inject_cyc);
                if (cyc == rise_cyc) begin
                    @(negedge clk);
                    man_sensor = 1'b1;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
    endtask

    task automatic full_run_checks(input string tag, input int inject_cyc, input int rise_cyc);
        int dc, dn;
        run(-1, inject_cyc, rise_cyc, dc, dn);
        check({tag, "_done_count"}, dn, 1);
        check({tag, "_done_cycle"}, dc, RUN_LEN);
        check({tag, "_codes_drained"}, code_q.size(), 0);
    endtask

    initial begin
        int dc, dn, dseen, w;
        rst_n      = 1'b0;
        start      = 1'b0;
        sat_start  = 1'b0;
        man_sensor = 1'b0;
        gen_en     = 1'b1;

        // Reset with the sensor toggling
        repeat (3) @(posedge clk);
        #1;
        check("reset_counts", {r_cnt, g_cnt} | {b_cnt, c_cnt}, 32'd0);
        check("reset_flags", {26'd0, ovf, busy, done}, 32'd0);
        check("reset_sel", {30'd0, s2, s3}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("idle_counts", {r_cnt, g_cnt} | {b_cnt, c_cnt}, 32'd0);
        check("idle_flags", {26'd0, ovf, busy, done}, 32'd0);

        // Nominal run
        push_run(10, 5, 4, 20, 0, 1);
        full_run_checks("nominal", -1, -1);

        // Start pulsed mid green GATE must be ignored
        push_run(10, 5, 4, 20, 0, 1);
        full_run_checks("busy_start", 150, -1);

        // Immediate restart with a silent sensor overwrites the counts
        gen_en     = 1'b0;
        man_sensor = 1'b0;
        push_run(0, 0, 0, 0, 0, 0);
        full_run_checks("const", -1, -1);

        // Single edge whose pulse lands on the last green SETTLE cycle
        push_run(0, 0, 0, 0, 0, 0);
        full_run_checks("edge_settle", -1, PER_CH + 1);

        // Single edge whose pulse lands on the last green GATE cycle
        man_sensor = 1'b0;
        repeat (5) @(posedge clk);
        push_run(0, 1, 0, 0, 0, 0);
        full_run_checks("edge_gate_end", -1, PER_CH + SETTLE + GATE - 3);

        // Reset during blue GATE
        man_sensor = 1'b0;
        gen_en     = 1'b1;
        code_q.push_back(0);
        code_q.push_back(3);
        code_q.push_back(1);
        run(2 * PER_CH + SETTLE + 50, -1, -1, dc, dn);
        check("partial_no_done", dn, 0);
        check("partial_codes_drained", code_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_counts", {r_cnt, g_cnt} | {b_cnt, c_cnt}, 32'd0);
        check("midrst_flags", {26'd0, ovf, busy, done}, 32'd0);
        check("midrst_sel", {30'd0, s2, s3}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dseen++;
        end
        check("midrst_no_done", dseen, 0);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        push_run(10, 5, 4, 20, 0, 1);
        full_run_checks("after_rst", -1, -1);

        // Saturation on the narrow-counter instance
        @(negedge clk);
        sat_start = 1'b1;
        @(posedge clk);
        #1;
        sat_start = 1'b0;
        w = 0;
        while (sat_done !== 1'b1 && w < BUDGET) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("sat_done_cycle", w, RUN_LEN);
        check("sat_r", {28'd0, sat_r}, 32'd15);
        check("sat_g", {28'd0, sat_g}, 32'd15);
        check("sat_b", {28'd0, sat_b}, 32'd15);
        check("sat_c", {28'd0, sat_c}, 32'd15);
        check("sat_ovf", {28'd0, sat_ovf}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
